// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch: captures execute-stage results, rewrites ALU
// overflows on add/addi/sub into a $rstatus write, resolves bne/blt into a
// registered redirect, and tracks a sticky exception flag plus a saturating
// exception counter for debug.
module ex_mem_stage #(
   parameter int unsigned CNT_W       = 8,
   parameter logic [4:0]  RSTATUS_REG = 5'd30
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             clr_exc,
   input  logic             in_valid,
   input  logic [4:0]       in_opcode,
   input  logic [4:0]       in_aluop,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_imm,
   input  logic [4:0]       in_rd,
   input  logic             in_wren,
   input  logic             in_mem_we,
   input  logic [31:0]      in_store_data,
   input  logic [31:0]      in_alu_result,
   input  logic             in_overflow,
   input  logic             in_isNotEqual,
   input  logic             in_isLessThan,
   output logic             out_valid,
   output logic [31:0]      out_result,
   output logic [4:0]       out_rd,
   output logic             out_wren,
   output logic             out_mem_we,
   output logic [31:0]      out_store_data,
   output logic             out_redirect,
   output logic [31:0]      out_target,
   output logic             exc_sticky,
   output logic [CNT_W-1:0] exc_count
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Status code for instructions that trap on overflow; 0 means "never traps".
   function automatic logic [1:0] exc_code_f(input logic [4:0] opcode, input logic [4:0] aluop);
      logic [1:0] code;
      code = 2'd0;
      case (opcode)
         OP_RTYPE: begin
            case (aluop)
               ALU_ADD: code = 2'd1;
               ALU_SUB: code = 2'd3;
               default: code = 2'd0;
            endcase
         end
         OP_ADDI: code = 2'd2;
         default: code = 2'd0;
      endcase
      return code;
   endfunction

   logic             valid_q, valid_d;
   logic [31:0]      result_q, result_d;
   logic [4:0]       rd_q, rd_d;
   logic             wren_q, wren_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      store_data_q, store_data_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      target_q, target_d;
   logic             exc_sticky_q, exc_sticky_d;
   logic [CNT_W-1:0] exc_count_q, exc_count_d;

   logic [1:0] code_s;
   logic       exc_s;
   logic       is_branch_s;
   logic       taken_s;
   logic       exc_load_s;

   // Decode exception and branch conditions from the incoming instruction.
   always_comb begin
      code_s      = exc_code_f(in_opcode, in_aluop);
      exc_s       = in_valid & in_overflow & (code_s != 2'd0);
      is_branch_s = (in_opcode == OP_BNE) | (in_opcode == OP_BLT);
      taken_s     = in_valid & (((in_opcode == OP_BNE) & in_isNotEqual) |
                                ((in_opcode == OP_BLT) & in_isLessThan));
      exc_load_s  = ~flush & ~stall & exc_s;
   end

   // Next latch contents: flush beats stall beats load; invalid input loads a bubble.
   always_comb begin
      valid_d      = valid_q;
      result_d     = result_q;
      rd_d         = rd_q;
      wren_d       = wren_q;
      mem_we_d     = mem_we_q;
      store_data_d = store_data_q;
      redirect_d   = redirect_q;
      target_d     = target_q;
      if (flush || (!stall && !in_valid)) begin
         valid_d      = 1'b0;
         result_d     = 32'd0;
         rd_d         = 5'd0;
         wren_d       = 1'b0;
         mem_we_d     = 1'b0;
         store_data_d = 32'd0;
         redirect_d   = 1'b0;
         target_d     = 32'd0;
      end else if (stall) begin
         valid_d      = valid_q;
         redirect_d   = redirect_q;
      end else begin
         valid_d      = 1'b1;
         result_d     = exc_s ? {30'd0, code_s} : in_alu_result;
         rd_d         = exc_s ? RSTATUS_REG : in_rd;
         wren_d       = exc_s ? 1'b1 : (is_branch_s ? 1'b0 : in_wren);
         mem_we_d     = is_branch_s ? 1'b0 : in_mem_we;
         store_data_d = in_store_data;
         redirect_d   = taken_s;
         target_d     = taken_s ? (in_pc + 32'd1 + in_imm) : 32'd0;
      end
   end

   // Sticky flag and saturating counter; a clear wins over a same-cycle exception.
   always_comb begin
      exc_sticky_d = exc_sticky_q;
      exc_count_d  = exc_count_q;
      if (clr_exc) begin
         exc_sticky_d = 1'b0;
         exc_count_d  = exc_load_s ? CNT_ONE : CNT_ZERO;
      end else if (exc_load_s) begin
         exc_sticky_d = 1'b1;
         exc_count_d  = (exc_count_q == CNT_MAX) ? exc_count_q : (exc_count_q + CNT_ONE);
      end else begin
         exc_sticky_d = exc_sticky_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q      <= 1'b0;
         result_q     <= 32'd0;
         rd_q         <= 5'd0;
         wren_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         store_data_q <= 32'd0;
         redirect_q   <= 1'b0;
         target_q     <= 32'd0;
         exc_sticky_q <= 1'b0;
         exc_count_q  <= CNT_ZERO;
      end else begin
         valid_q      <= valid_d;
         result_q     <= result_d;
         rd_q         <= rd_d;
         wren_q       <= wren_d;
         mem_we_q     <= mem_we_d;
         store_data_q <= store_data_d;
         redirect_q   <= redirect_d;
         target_q     <= target_d;
         exc_sticky_q <= exc_sticky_d;
         exc_count_q  <= exc_count_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_result     = result_q;
   assign out_rd         = rd_q;
   assign out_wren       = wren_q;
   assign out_mem_we     = mem_we_q;
   assign out_store_data = store_data_q;
   assign out_redirect   = redirect_q;
   assign out_target     = target_q;
   assign exc_sticky     = exc_sticky_q;
   assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a vector table replayed through a
// scoreboard queue, followed by hand-written saturation and async-reset sequences.
module tb_ex_mem_stage;

   typedef struct packed {
      logic        stall, flush, clr, valid;
      logic [4:0]  opcode, aluop;
      logic [31:0] pc, imm;
      logic [4:0]  rd;
      logic        wren, mw;
      logic [31:0] sd, alu;
      logic        ovf, ne, lt;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wren, mw;
      logic [31:0] sd;
      logic        redir;
      logic [31:0] tgt;
      logic        sticky;
      logic [7:0]  cnt;
   } out_t;

   logic        clock, reset, stall, flush, clr_exc, in_valid;
   logic [4:0]  in_opcode, in_aluop, in_rd;
   logic [31:0] in_pc, in_imm, in_store_data, in_alu_result;
   logic        in_wren, in_mem_we, in_overflow, in_isNotEqual, in_isLessThan;
   logic        out_valid, out_wren, out_mem_we, out_redirect, exc_sticky;
   logic [31:0] out_result, out_store_data, out_target;
   logic [4:0]  out_rd;
   logic [7:0]  exc_count;

   int tests = 0;
   int fails = 0;

   in_t  vin[$];
   out_t vout[$];
   out_t expq[$];

   ex_mem_stage #(.CNT_W(8), .RSTATUS_REG(5'd30)) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .clr_exc(clr_exc),
      .in_valid(in_valid), .in_opcode(in_opcode), .in_aluop(in_aluop), .in_pc(in_pc),
      .in_imm(in_imm), .in_rd(in_rd), .in_wren(in_wren), .in_mem_we(in_mem_we),
      .in_store_data(in_store_data), .in_alu_result(in_alu_result),
      .in_overflow(in_overflow), .in_isNotEqual(in_isNotEqual), .in_isLessThan(in_isLessThan),
      .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd), .out_wren(out_wren),
      .out_mem_we(out_mem_we), .out_store_data(out_store_data), .out_redirect(out_redirect),
      .out_target(out_target), .exc_sticky(exc_sticky), .exc_count(exc_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic out_t get_out();
      out_t o;
      o = '{out_valid, out_result, out_rd, out_wren, out_mem_we, out_store_data,
            out_redirect, out_target, exc_sticky, exc_count};
      return o;
   endfunction

   task automatic drive(input in_t v);
      stall = v.stall; flush = v.flush; clr_exc = v.clr; in_valid = v.valid;
      in_opcode = v.opcode; in_aluop = v.aluop; in_pc = v.pc; in_imm = v.imm;
      in_rd = v.rd; in_wren = v.wren; in_mem_we = v.mw; in_store_data = v.sd;
      in_alu_result = v.alu; in_overflow = v.ovf; in_isNotEqual = v.ne; in_isLessThan = v.lt;
   endtask

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = get_out();
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus at negedge and settle just after the posedge.
   task automatic cycle(input in_t v);
      @(negedge clock);
      drive(v);
      @(posedge clock);
      #1;
   endtask

   localparam in_t ADD_OVF = '{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,32'd0,5'd1,1'b1,1'b0,32'd0,32'h8000_0000,1'b1,1'b0,1'b0};
   localparam in_t IDLE    = '{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,32'd0,32'd0,5'd0,1'b0,1'b0,32'd0,32'd0,1'b0,1'b0,1'b0};

   initial begin
      in_t  v;
      out_t e;
      reset = 1'b0;
      drive(IDLE);
      #12;
      check("reset_state", '0);

      //                 stall flush clr  valid opcode    aluop     pc             imm            rd    wren mw   sd             alu            ovf  ne   lt
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd4, 1'b1,1'b0,32'd0,         32'h0000_0005,1'b0,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd7, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00101,5'b00000,32'd0,         32'd0,         5'd8, 1'b1,1'b0,32'd0,         32'h8000_0005,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00001,32'd0,         32'd0,         5'd9, 1'b1,1'b0,32'd0,         32'h7FFF_FFFF,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00010,32'd0,         32'd0,         5'd3, 1'b1,1'b0,32'd0,         32'h0000_1234,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00010,5'b00000,32'h10,        32'hFFFF_FFFC, 5'd0, 1'b1,1'b0,32'd0,         32'd1,        1'b0,1'b1,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00010,5'b00000,32'h10,        32'hFFFF_FFFC, 5'd0, 1'b0,1'b0,32'd0,         32'd1,        1'b0,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00110,5'b00000,32'hFFFF_FFF0, 32'h20,        5'd0, 1'b0,1'b0,32'd0,         32'd1,        1'b0,1'b0,1'b1});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00111,5'b00000,32'd0,         32'd0,         5'd0, 1'b0,1'b1,32'hCAFE_BABE, 32'h100,      1'b0,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b0,5'b00000,5'b00000,32'd0,         32'd0,         5'd5, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b1,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd5, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd5, 1'b1,1'b0,32'd0,         32'h77,       1'b0,1'b0,1'b0});
      vin.push_back('{1'b1,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd9, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b1,1'b0,1'b0,1'b1,5'b00010,5'b00000,32'h40,        32'd4,         5'd0, 1'b0,1'b0,32'd0,         32'd0,        1'b0,1'b1,1'b0});
      vin.push_back('{1'b1,1'b0,1'b0,1'b1,5'b00111,5'b00000,32'd0,         32'd0,         5'd0, 1'b0,1'b1,32'h1111_2222, 32'h8,        1'b0,1'b0,1'b0});
      vin.push_back('{1'b1,1'b1,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd5, 1'b1,1'b0,32'd0,         32'h55,       1'b0,1'b0,1'b0});
      vin.push_back('{1'b1,1'b0,1'b1,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd5, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b1,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd6, 1'b1,1'b0,32'd0,         32'h8000_0000,1'b1,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00010,5'b00000,32'h100,       32'h10,        5'd0, 1'b0,1'b0,32'd0,         32'd0,        1'b0,1'b1,1'b0});
      vin.push_back('{1'b1,1'b0,1'b0,1'b1,5'b00000,5'b00000,32'd0,         32'd0,         5'd2, 1'b1,1'b0,32'd0,         32'h9,        1'b0,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b0,5'b00000,5'b00000,32'd0,         32'd0,         5'd0, 1'b0,1'b0,32'd0,         32'd0,        1'b0,1'b0,1'b0});
      vin.push_back('{1'b0,1'b0,1'b0,1'b1,5'b00101,5'b00000,32'd0,         32'd0,         5'd2, 1'b1,1'b0,32'd0,         32'hFFFF_FFFF,1'b0,1'b0,1'b0});

      //               valid result         rd     wren mw   sd             redir tgt          sticky cnt
      vout.push_back('{1'b1,32'h0000_0005, 5'd4,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b0,8'd0});
      vout.push_back('{1'b1,32'd1,         5'd30, 1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd1});
      vout.push_back('{1'b1,32'd2,         5'd30, 1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd2});
      vout.push_back('{1'b1,32'd3,         5'd30, 1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'h0000_1234, 5'd3,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'd1,         5'd0,  1'b0,1'b0,32'd0,         1'b1,32'h0D,       1'b1,8'd3});
      vout.push_back('{1'b1,32'd1,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'd1,         5'd0,  1'b0,1'b0,32'd0,         1'b1,32'h11,       1'b1,8'd3});
      vout.push_back('{1'b1,32'h100,       5'd0,  1'b0,1'b1,32'hCAFE_BABE, 1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b0,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b0,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'h77,        5'd5,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'h77,        5'd5,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'h77,        5'd5,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b1,32'h77,        5'd5,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b0,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b1,8'd3});
      vout.push_back('{1'b0,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b0,8'd0});
      vout.push_back('{1'b1,32'd1,         5'd30, 1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b0,8'd1});
      vout.push_back('{1'b1,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b1,32'h111,      1'b0,8'd1});
      vout.push_back('{1'b1,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b1,32'h111,      1'b0,8'd1});
      vout.push_back('{1'b0,32'd0,         5'd0,  1'b0,1'b0,32'd0,         1'b0,32'd0,        1'b0,8'd1});
      vout.push_back('{1'b1,32'hFFFF_FFFF, 5'd2,  1'b1,1'b0,32'd0,         1'b0,32'd0,        1'b0,8'd1});

      @(negedge clock);
      reset = 1'b1;

      // Table replay through the scoreboard.
      for (int i = 0; i < vin.size(); i++) begin
         @(negedge clock);
         drive(vin[i]);
         expq.push_back(vout[i]);
         @(posedge clock);
         #1;
         e = expq.pop_front();
         check($sformatf("vec%0d", i), e);
      end

      // Saturation: count is 1 here; 254 more overflows reach 255, 46 more stay there.
      for (int i = 0; i < 254; i++) cycle(ADD_OVF);
      check("sat_reach", '{1'b1,32'd1,5'd30,1'b1,1'b0,32'd0,1'b0,32'd0,1'b1,8'd255});
      for (int i = 0; i < 46; i++) cycle(ADD_OVF);
      check("sat_hold", '{1'b1,32'd1,5'd30,1'b1,1'b0,32'd0,1'b0,32'd0,1'b1,8'd255});
      v = IDLE; v.clr = 1'b1;
      cycle(v);
      check("clr_only", '0);
      v = ADD_OVF; v.clr = 1'b1;
      cycle(v);
      check("clr_with_exc", '{1'b1,32'd1,5'd30,1'b1,1'b0,32'd0,1'b0,32'd0,1'b0,8'd1});

      // Asynchronous reset mid-cycle while a taken branch is latched.
      v = IDLE; v.valid = 1'b1; v.opcode = 5'b00010; v.pc = 32'h10; v.imm = 32'hFFFF_FFFC; v.ne = 1'b1;
      cycle(v);
      check("pre_reset_branch", '{1'b1,32'd0,5'd0,1'b0,1'b0,32'd0,1'b1,32'h0D,1'b0,8'd1});
      #2 reset = 1'b0;
      #1;
      check("async_reset", '0);
      @(posedge clock);
      #1;
      check("reset_held", '0);
      v = IDLE; v.valid = 1'b1; v.rd = 5'd4; v.wren = 1'b1; v.alu = 32'd5;
      @(negedge clock);
      reset = 1'b1;
      drive(v);
      @(posedge clock);
      #1;
      check("load_after_reset", '{1'b1,32'd5,5'd4,1'b1,1'b0,32'd0,1'b0,32'd0,1'b0,8'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
